clock_divider_prog: RTL and testbench

Parametrised, runtime-programmable clock-enable generator for the Spartan-3 seven-segment display path. It divides the board clock by a loadable ratio and exposes three outputs: a one-cycle `tick` strobe for digit multiplexing and debouncing, a near-50% `div_clk` square wave, and the live count bus `data_clk`. It supports continuous and one-shot modes. Ratio and mode changes are glitch-free and take effect only at period boundaries.

---
 rtl/clock_divider_prog.sv | 117 +++++++++++
 tb/tb_clock_divider_prog.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock-enable generator: divides clk by a loadable ratio and
// produces a tick strobe, a near-50% divided clock, the live count, and one-shot support.
module clock_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  input  logic             mode,
  input  logic             start,
  output logic             tick,
  output logic             div_clk,
  output logic [WIDTH-1:0] data_clk,
  output logic             busy,
  output logic             load_ack
);

  localparam logic [WIDTH-1:0] MIN_DIV     = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_RAW     = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_CLAMPED = (DEF_RAW < MIN_DIV) ? MIN_DIV : DEF_RAW;

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic [WIDTH-1:0] pending_div_q, pending_div_d;
  logic             pending_valid_q, pending_valid_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             div_clk_q, div_clk_d;
  logic             load_ack_q, load_ack_d;

  logic             running;
  logic             count_en;
  logic             wrap;
  logic             apply;

  assign running  = ~mode_q | busy_q;
  assign count_en = running & enable;
  assign wrap     = count_en & (count_q == (active_div_q - WIDTH'(1)));
  // Pending ratio goes live at a period boundary, or right away when nothing is counting.
  assign apply    = pending_valid_q & (wrap | (~running & enable));

  always_comb begin
    count_d         = count_q;
    active_div_d    = active_div_q;
    pending_div_d   = pending_div_q;
    pending_valid_d = pending_valid_q;
    mode_d          = mode_q;
    busy_d          = busy_q;
    div_clk_d       = div_clk_q;
    tick_d          = wrap;
    load_ack_d      = apply;

    if (count_en) begin
      count_d   = wrap ? '0 : count_q + WIDTH'(1);
      div_clk_d = (count_q < (active_div_q >> 1));
    end

    if (apply) begin
      active_div_d    = pending_div_q;
      pending_valid_d = 1'b0;
    end
    // A capture on the same edge as an apply is kept for the following boundary.
    if (div_load) begin
      pending_div_d   = clamp_div(div_value);
      pending_valid_d = 1'b1;
    end

    if (wrap || (mode_q && !busy_q)) begin
      mode_d = mode;
    end

    if (busy_q && wrap) begin
      busy_d = 1'b0;
    end else if (!busy_q && mode_q && start) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q         <= '0;
      active_div_q    <= DEF_CLAMPED;
      pending_div_q   <= DEF_CLAMPED;
      pending_valid_q <= 1'b0;
      mode_q          <= mode;
      busy_q          <= 1'b0;
      tick_q          <= 1'b0;
      div_clk_q       <= 1'b0;
      load_ack_q      <= 1'b0;
    end else begin
      count_q         <= count_d;
      active_div_q    <= active_div_d;
      pending_div_q   <= pending_div_d;
      pending_valid_q <= pending_valid_d;
      mode_q          <= mode_d;
      busy_q          <= busy_d;
      tick_q          <= tick_d;
      div_clk_q       <= div_clk_d;
      load_ack_q      <= load_ack_d;
    end
  end

  assign tick     = tick_q;
  assign div_clk  = div_clk_q;
  assign data_clk = count_q;
  assign busy     = busy_q;
  assign load_ack = load_ack_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: fixed vector table, directed corner sequences and
// randomized traffic, all checked against a cycle-level behavioural reference.
module tb_clock_divider_prog;

  localparam int W   = 16;
  localparam int DEF = 4;

  // Inputs are sampled on the rising edge; outputs are checked 1 time unit later.
  logic         clk = 1'b0;
  logic         reset, enable, div_load, mode, start;
  logic [W-1:0] div_value;
  logic         tick, div_clk, busy, load_ack;
  logic [W-1:0] data_clk;

  clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_value(div_value),
    .div_load(div_load), .mode(mode), .start(start), .tick(tick),
    .div_clk(div_clk), .data_clk(data_clk), .busy(busy), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Reference state, plain integers.
  int m_count = 0, m_active = DEF, m_pend = 0;
  bit m_pvalid = 0, m_mode = 0, m_busy = 0, m_tick = 0, m_div = 0, m_ack = 0;

  typedef struct {
    bit rst, en, ld;
    int val;
    int e_data;
    bit e_tick, e_div, e_ack;
  } vec_t;
  vec_t tbl[21];

  function automatic vec_t mk(bit rst, bit en, bit ld, int val, int ed, bit et, bit ediv, bit eack);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.val = val;
    v.e_data = ed; v.e_tick = et; v.e_div = ediv; v.e_ack = eack;
    return v;
  endfunction

  function automatic int clampi(int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference by one rising edge using the inputs currently driven.
  task automatic model_step();
    bit run, cnt, at_end, old_mode, old_busy;
    if (reset) begin
      m_count = 0; m_active = clampi(DEF); m_pvalid = 0; m_mode = mode;
      m_busy = 0; m_tick = 0; m_div = 0; m_ack = 0;
      return;
    end
    run    = !m_mode || m_busy;
    cnt    = run && enable;
    at_end = cnt && (m_count == m_active - 1);
    m_tick = at_end;
    m_ack  = 0;
    if (cnt) begin
      m_div   = (m_count < m_active / 2);
      m_count = (m_count + 1) % m_active;
    end
    if (m_pvalid && (at_end || (!run && enable))) begin
      m_active = m_pend; m_pvalid = 0; m_ack = 1;
    end
    if (div_load) begin
      m_pend = clampi(int'(div_value)); m_pvalid = 1;
    end
    old_mode = m_mode;
    old_busy = m_busy;
    if (at_end || (old_mode && !old_busy)) m_mode = mode;
    if (old_busy && at_end) m_busy = 0;
    else if (!old_busy && old_mode && start) m_busy = 1;
  endtask

  task automatic step();
    model_step();
    exp_q.push_back(W'(m_count));
    @(posedge clk);
    #1;
    check("model_data_clk", data_clk, exp_q.pop_front());
    check("model_tick", tick, m_tick);
    check("model_div_clk", div_clk, m_div);
    check("model_busy", busy, m_busy);
    check("model_load_ack", load_ack, m_ack);
  endtask

  task automatic load(input int v);
    div_value = W'(v);
    div_load  = 1'b1;
    step();
    div_load  = 1'b0;
  endtask

  task automatic wait_ack(input int budget, input string name);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (load_ack) begin got = 1; break; end
    end
    check(name, got, 1);
  endtask

  task automatic wait_data(input int val, input int budget, input string name);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (data_clk == W'(val)) begin got = 1; break; end
    end
    check(name, got, 1);
  endtask

  initial begin
    int ticks, busy_cycles;
    reset = 1'b1; enable = 1'b1; div_load = 1'b0; mode = 1'b0; start = 1'b0;
    div_value = '0;

    // Continuous N=4, then a load of 7 at count 1.
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 0, 1, 0);
    tbl[2]  = mk(0, 1, 0, 0, 2, 0, 1, 0);
    tbl[3]  = mk(0, 1, 0, 0, 3, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 1, 0, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 2, 0, 1, 0);
    tbl[7]  = mk(0, 1, 0, 0, 3, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 1, 0, 1, 0);
    tbl[10] = mk(0, 1, 1, 7, 2, 0, 1, 0);
    tbl[11] = mk(0, 1, 0, 0, 3, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 1, 0, 1);
    tbl[13] = mk(0, 1, 0, 0, 1, 0, 1, 0);
    tbl[14] = mk(0, 1, 0, 0, 2, 0, 1, 0);
    tbl[15] = mk(0, 1, 0, 0, 3, 0, 1, 0);
    tbl[16] = mk(0, 1, 0, 0, 4, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 5, 0, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 6, 0, 0, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 1, 0, 0);
    tbl[20] = mk(0, 1, 0, 0, 1, 0, 1, 0);

    for (int i = 0; i < 21; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; div_load = tbl[i].ld;
      div_value = W'(tbl[i].val);
      step();
      check("vec_data_clk", data_clk, W'(tbl[i].e_data));
      check("vec_tick", tick, tbl[i].e_tick);
      check("vec_div_clk", div_clk, tbl[i].e_div);
      check("vec_busy", busy, 0);
      check("vec_load_ack", load_ack, tbl[i].e_ack);
    end
    div_load = 1'b0;

    // Clamp: ratios 0 and 1 both behave as 2.
    load(0);
    wait_ack(10, "ack_clamp0");
    for (int i = 0; i < 4; i++) begin step(); check("clamp0_tick", tick, i % 2); end
    load(1);
    wait_ack(4, "ack_clamp1");
    for (int i = 0; i < 4; i++) begin step(); check("clamp1_tick", tick, i % 2); end

    // Enable gating at count 2 with N=4.
    load(4);
    wait_ack(4, "ack_n4");
    wait_data(2, 8, "reach_count2");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("gated_data_clk", data_clk, 2);
      check("gated_tick", tick, 0);
    end
    enable = 1'b1;
    step(); check("resume1_data", data_clk, 3); check("resume1_tick", tick, 0);
    step(); check("resume2_data", data_clk, 0); check("resume2_tick", tick, 1);

    // One-shot with N=5; extra starts mid-shot and on the final edge.
    load(5);
    wait_ack(6, "ack_n5");
    mode = 1'b1;
    repeat (6) step();
    check("idle_data", data_clk, 0);
    check("idle_busy", busy, 0);
    start = 1'b1; step(); start = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_data", data_clk, 0);
    ticks = 0; busy_cycles = 1;
    for (int k = 1; k <= 5; k++) begin
      start = (k == 2 || k == 5);
      step();
      start = 1'b0;
      ticks += int'(tick);
      busy_cycles += int'(busy);
      if (k < 5) check("shot_data", data_clk, k);
    end
    check("shot_end_tick", tick, 1);
    check("shot_end_busy", busy, 0);
    check("shot_busy_cycles", busy_cycles, 5);
    for (int k = 0; k < 3; k++) begin
      step();
      ticks += int'(tick);
      check("after_shot_data", data_clk, 0);
      check("after_shot_busy", busy, 0);
    end
    check("shot_tick_count", ticks, 1);

    // Idle load applies on the very next edge.
    load(6);
    check("idle_ack_early", load_ack, 0);
    step();
    check("idle_ack", load_ack, 1);

    // Reset mid-period discards a pending load.
    mode = 1'b0;
    step();
    wait_data(2, 12, "reach_count2_n6");
    load(9);
    check("pre_reset_data", data_clk, 3);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_tick", tick, 0);
    check("rst_div_clk", div_clk, 0);
    check("rst_data_clk", data_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_load_ack", load_ack, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("post_rst_tick", tick, (k % 4) == 0);
      check("post_rst_no_ack", load_ack, 0);
    end

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      enable    = ($urandom_range(0, 4) != 0);
      div_load  = ($urandom_range(0, 11) == 0);
      div_value = W'($urandom_range(0, 9));
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      start     = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
